// File: rtl/m_axi_lite_arb.sv
// Round-robin arbiter for two requesters that share one AXI4-Lite master port.
// Only one transaction is in flight at a time. Completion is a one-cycle pulse to the owning requester.
module m_axi_lite_arb #(
  parameter int DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic [1:0]            cmd_valid,
  output logic [1:0]            cmd_ready,
  input  logic [1:0]            cmd_we,
  input  logic [2*DWIDTH-1:0]   cmd_addr,
  input  logic [2*DWIDTH-1:0]   cmd_wdata,
  output logic [1:0]            rsp_valid,
  output logic [DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  busy,
  output logic                  grant,
  output logic                  awvalid,
  output logic [DWIDTH-1:0]     awaddr,
  output logic [2:0]            awprot,
  input  logic                  awready,
  output logic                  wvalid,
  output logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH/8-1:0]   wstrb,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic                  arvalid,
  output logic [DWIDTH-1:0]     araddr,
  output logic [2:0]            arprot,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic [DWIDTH-1:0]     rdata,
  input  logic [1:0]            rresp,
  output logic                  rready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_e;

  state_e              state_q;
  logic                we_q;
  logic [DWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                grant_q;
  logic                prio_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                arvalid_q;
  logic                bready_q;
  logic                rready_q;
  logic [1:0]          rsp_valid_q;
  logic [DWIDTH-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;

  logic                arb_sel;
  logic                accept;
  logic                sel_we;
  logic [DWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_wdata;
  logic                aw_ok;
  logic                w_ok;

  // When both requesters are valid, prio_q names the one that was not granted last.
  always_comb begin
    arb_sel = 1'b0;
    case (cmd_valid)
      2'b01:   arb_sel = 1'b0;
      2'b10:   arb_sel = 1'b1;
      2'b11:   arb_sel = prio_q;
      default: arb_sel = 1'b0;
    endcase
  end

  // The xrst term keeps cmd_ready low while reset is held, even when the FSM is idle.
  assign accept    = xrst && (state_q == S_IDLE) && (cmd_valid != 2'b00);
  assign cmd_ready = accept ? (arb_sel ? 2'b10 : 2'b01) : 2'b00;
  assign sel_we    = arb_sel ? cmd_we[1] : cmd_we[0];
  assign sel_addr  = arb_sel ? cmd_addr[2*DWIDTH-1:DWIDTH]  : cmd_addr[DWIDTH-1:0];
  assign sel_wdata = arb_sel ? cmd_wdata[2*DWIDTH-1:DWIDTH] : cmd_wdata[DWIDTH-1:0];

  // Each write channel counts as done once its valid has dropped or is handshaking now.
  assign aw_ok = ~awvalid_q | awready;
  assign w_ok  = ~wvalid_q  | wready;

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            grant_q   <= arb_sel;
            prio_q    <= ~arb_sel;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            awvalid_q <= sel_we;
            wvalid_q  <= sel_we;
            arvalid_q <= ~sel_we;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (we_q) begin
            if (awready) awvalid_q <= 1'b0;
            if (wready)  wvalid_q  <= 1'b0;
            if (aw_ok && w_ok) begin
              bready_q <= 1'b1;
              state_q  <= S_RESP;
            end
          end else if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          if (we_q && bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= {grant_q, ~grant_q};
            state_q     <= S_DONE;
          end else if (!we_q && rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= rresp;
            rsp_rdata_q <= rdata;
            rsp_valid_q <= {grant_q, ~grant_q};
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_valid_q <= 2'b00;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign busy      = (state_q != S_IDLE);
  assign grant     = grant_q;

  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = '1;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign arprot    = 3'b000;
  assign rready    = rready_q;

endmodule

// File: tb/tb_m_axi_lite_arb.sv
// Bench for m_axi_lite_arb: directed commands, a scripted AXI-Lite slave and a
// response scoreboard popped by an independent monitor.
`timescale 1ns/1ps
module tb_m_axi_lite_arb;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          xrst = 1'b0;
  logic [1:0]    cmd_valid = 2'b00;
  logic [1:0]    cmd_ready;
  logic [1:0]    cmd_we = 2'b00;
  logic [2*DW-1:0] cmd_addr = '0;
  logic [2*DW-1:0] cmd_wdata = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          busy, grant;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] awaddr, wdata, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW/8-1:0] wstrb;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = 2'b00, rresp = 2'b00;
  logic [DW-1:0] rdata = '0;

  m_axi_lite_arb #(.DWIDTH(DW)) dut (
    .clk(clk), .xrst(xrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .grant(grant),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  // ---------------- scripted slave ----------------
  int          aw_wait = 0, w_wait = 0;
  bit          b_early = 0, b_hold = 0, r_echo = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_vcyc, w_vcyc, b_early_err;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;
  bit          aw_got, w_got, ar_pend, r_drop, b_drop;

  // Inputs change only at negedge and DUT outputs only at posedge, so valid&&ready
  // evaluated here is exactly the handshake taken at the following posedge.
  always @(negedge clk) begin
    if (!xrst) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_got = 0; w_got = 0; ar_pend = 0; r_drop = 0; b_drop = 0;
    end else begin
      if (b_drop) bvalid = 0;
      b_drop = 0;
      if (r_drop) rvalid = 0;
      r_drop = 0;
      if (ar_pend) begin
        rvalid = 1; rdata = r_echo ? cap_araddr : rdata_cfg; rresp = rresp_cfg; ar_pend = 0;
      end
      if (aw_got && w_got && !bvalid && !b_hold) begin bvalid = 1; bresp = bresp_cfg; end
      if (b_early && awvalid && !bvalid) begin bvalid = 1; bresp = bresp_cfg; end

      awready = awvalid && (aw_wait == 0);
      if (awvalid && aw_wait > 0) aw_wait--;
      if (awvalid) aw_vcyc++;
      if (awvalid && awready) begin aw_hs++; aw_got = 1; cap_awaddr = awaddr; cap_awprot = awprot; end

      wready = wvalid && (w_wait == 0);
      if (wvalid && w_wait > 0) w_wait--;
      if (wvalid) w_vcyc++;
      if (wvalid && wready) begin w_hs++; w_got = 1; cap_wdata = wdata; cap_wstrb = wstrb; end

      arready = arvalid;
      if (arvalid) begin ar_hs++; ar_pend = 1; cap_araddr = araddr; cap_arprot = arprot; end

      if (bready && (awvalid || wvalid)) b_early_err++;
      if (bvalid && bready) begin b_hs++; b_drop = 1; aw_got = 0; w_got = 0; end
      if (rvalid && rready) begin r_hs++; r_drop = 1; end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { int owner; logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t expq[$];
  int rsp_cnt = 0, rsp_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (xrst && rsp_valid != 2'b00) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp actual=%b required=none", rsp_valid);
      end else begin
        e = expq.pop_front();
        chk("rsp_valid", 64'(rsp_valid), (e.owner == 1) ? 64'h2 : 64'h1);
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        $display("rsp owner=%0d rdata=%08h resp=%0d cyc=%0d", e.owner, rsp_rdata, rsp_resp, cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_q[$];
  int grant_log[$];
  int acc_cyc = 0;

  task automatic drive(input int r, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic [1:0] eresp);
    exp_t e;
    int n;
    @(negedge clk);
    cmd_valid[r] = 1'b1;
    cmd_we[r] = we;
    cmd_addr[r*DW +: DW] = a;
    cmd_wdata[r*DW +: DW] = d;
    #1;
    n = 0;
    while (!cmd_ready[r] && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!cmd_ready[r]) begin
      fail_now("accept_timeout");
      cmd_valid[r] = 1'b0;
      return;
    end
    e.owner = r; e.rdata = er; e.resp = eresp;
    expq.push_back(e);
    acc_q.push_back(cyc);
    grant_log.push_back(r);
    acc_cyc = cyc;
    $display("cmd req=%0d we=%0d addr=%08h wdata=%08h cyc=%0d", r, we, a, d, cyc);
    @(posedge clk); #1;
    cmd_valid[r] = 1'b0;
    chk("grant", 64'(grant), 64'(r));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((expq.size() != 0 || busy) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) fail_now(name);
    @(negedge clk);
  endtask

  task automatic clr_stats();
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_vcyc = 0; w_vcyc = 0; b_early_err = 0; rsp_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    xrst = 0; cmd_valid = 2'b00;
    expq.delete();
    repeat (2) @(negedge clk);
    xrst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_gap;
    int n;
    clr_stats();
    cmd_valid = 2'b11;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
    chk("rst_axi", 64'({awvalid, wvalid, arvalid, bready, rready, busy}), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    cmd_valid = 2'b00;
    repeat (3) @(negedge clk);
    xrst = 1;

    // Single write from requester 0 with an always-ready slave.
    clr_stats();
    drive(0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h0, 2'b00);
    wait_done("t1_done");
    chk("t1_awaddr", 64'(cap_awaddr), 64'h1000);
    chk("t1_wdata", 64'(cap_wdata), 64'hA5A5A5A5);
    chk("t1_wstrb", 64'(cap_wstrb), 64'hF);
    chk("t1_awprot", 64'(cap_awprot), 64'h0);
    chk("t1_hs", 64'({aw_hs[3:0], w_hs[3:0], b_hs[3:0]}), 64'h111);
    chk("t1_rsp_cnt", 64'(rsp_cnt), 64'd1);
    chk("t1_latency", 64'(rsp_cyc - acc_cyc), 64'd3);

    // Both requesters hold valid for four reads each; slave echoes the address.
    do_reset();
    clr_stats();
    r_echo = 1;
    acc_q.delete();
    grant_log.delete();
    fork
      for (int k = 0; k < 4; k++) drive(0, 1'b0, 32'(32'h100 + 4*k), 32'h0, 32'(32'h100 + 4*k), 2'b00);
      for (int k = 0; k < 4; k++) drive(1, 1'b0, 32'(32'h200 + 4*k), 32'h0, 32'(32'h200 + 4*k), 2'b00);
    join
    wait_done("t2_done");
    r_echo = 0;
    chk("t2_accepts", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) chk("t2_grant_order", 64'(grant_log[k]), 64'(k % 2));
    bad_gap = 0;
    for (int k = 1; k < acc_q.size(); k++) if (acc_q[k] - acc_q[k-1] != 4) bad_gap++;
    chk("t2_accept_gap", 64'(bad_gap), 64'd0);
    chk("t2_rsp_cnt", 64'(rsp_cnt), 64'd8);
    chk("t2_ar_hs", 64'(ar_hs), 64'd8);

    // awready is given three cycles before wready.
    clr_stats();
    w_wait = 3;
    drive(0, 1'b1, 32'h2000, 32'h11223344, 32'h0, 2'b00);
    wait_done("t3_done");
    chk("t3_aw_cycles", 64'(aw_vcyc), 64'd1);
    chk("t3_w_cycles", 64'(w_vcyc), 64'd4);
    chk("t3_hs", 64'({aw_hs[3:0], w_hs[3:0], b_hs[3:0]}), 64'h111);
    chk("t3_wdata", 64'(cap_wdata), 64'h11223344);
    chk("t3_rsp_cnt", 64'(rsp_cnt), 64'd1);

    // Read that returns SLVERR, then a normal write.
    clr_stats();
    rdata_cfg = 32'hDEADBEEF;
    rresp_cfg = 2'b10;
    drive(1, 1'b0, 32'h3000, 32'h0, 32'hDEADBEEF, 2'b10);
    wait_done("t4_done");
    chk("t4_araddr", 64'(cap_araddr), 64'h3000);
    chk("t4_arprot", 64'(cap_arprot), 64'h0);
    repeat (2) @(negedge clk);
    chk("t4_hold_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("t4_hold_resp", 64'(rsp_resp), 64'h2);
    chk("t4_hold_valid", 64'(rsp_valid), 64'h0);
    rresp_cfg = 2'b00;
    drive(0, 1'b1, 32'h3004, 32'h00000055, 32'h0, 2'b00);
    wait_done("t4b_done");
    chk("t4_rsp_cnt", 64'(rsp_cnt), 64'd2);

    // Reset asserted mid-cycle while bready is high.
    clr_stats();
    b_hold = 1;
    drive(0, 1'b1, 32'h4000, 32'h00000066, 32'h0, 2'b00);
    n = 0;
    while (!bready && n < 50) begin @(negedge clk); n++; end
    if (!bready) fail_now("t5_bready_wait");
    #2;
    xrst = 0;
    expq.delete();
    cmd_valid = 2'b10;
    #1;
    chk("t5_async_axi", 64'({awvalid, wvalid, arvalid, bready, rready, busy}), 64'h0);
    chk("t5_async_rsp", 64'(rsp_valid), 64'h0);
    chk("t5_async_cmd_ready", 64'(cmd_ready), 64'h0);
    cmd_valid = 2'b00;
    b_hold = 0;
    repeat (2) @(negedge clk);
    xrst = 1;
    clr_stats();
    drive(1, 1'b1, 32'h5000, 32'h00000077, 32'h0, 2'b00);
    wait_done("t5_done");
    chk("t5_grant", 64'(grant), 64'h1);
    chk("t5_awaddr", 64'(cap_awaddr), 64'h5000);
    chk("t5_b_hs", 64'(b_hs), 64'd1);
    chk("t5_rsp_cnt", 64'(rsp_cnt), 64'd1);

    // B presented while the write is still in its address/data phase.
    clr_stats();
    b_early = 1;
    w_wait = 2;
    drive(1, 1'b1, 32'h6000, 32'h00000088, 32'h0, 2'b01);
    bresp_cfg = 2'b01;
    wait_done("t6_done");
    b_early = 0;
    bresp_cfg = 2'b00;
    chk("t6_bready_early", 64'(b_early_err), 64'd0);
    chk("t6_b_hs", 64'(b_hs), 64'd1);
    chk("t6_w_cycles", 64'(w_vcyc), 64'd3);
    chk("t6_rsp_cnt", 64'(rsp_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
